// File: rtl/mem_bus_arbiter.sv
// Shared main-memory arbiter: VGA reads at fixed top priority, CPU and UART loader
// alternate round-robin; a grant is held until memory acks or the transaction times out.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_prefetch,
  input  logic        vga_req,
  input  logic [31:0] vga_adr,
  output logic        vga_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdat,
  input  logic [3:0]  cpu_sel,
  output logic        cpu_ack,
  input  logic        uart_req,
  input  logic [31:0] uart_adr,
  input  logic [31:0] uart_wdat,
  input  logic [3:0]  uart_sel,
  output logic        uart_ack,
  output logic [31:0] rd_data,
  output logic        bus_err,
  output logic [1:0]  grant,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdat,
  output logic [3:0]  mem_sel,
  input  logic [31:0] mem_rdat,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OWN_CPU  = 2'b00;
  localparam logic [1:0] OWN_VGA  = 2'b01;
  localparam logic [1:0] OWN_UART = 2'b10;
  localparam logic [1:0] OWN_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    owner, owner_nxt;
  logic          rr_uart, rr_uart_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [31:0]   rd_data_nxt;
  logic          vga_ack_nxt, cpu_ack_nxt, uart_ack_nxt, bus_err_nxt;
  logic [1:0]    pick;

  // Requester selection; prefetch only suppresses the CPU/UART candidates.
  always_comb begin
    pick = OWN_NONE;
    if (vga_req) begin
      pick = OWN_VGA;
    end else if (!vga_prefetch) begin
      if (cpu_req && uart_req) begin
        pick = rr_uart ? OWN_UART : OWN_CPU;
      end else if (cpu_req) begin
        pick = OWN_CPU;
      end else if (uart_req) begin
        pick = OWN_UART;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_NONE;
      rr_uart  <= 1'b0;
      timer    <= '0;
      rd_data  <= '0;
      vga_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      uart_ack <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_uart  <= rr_uart_nxt;
      timer    <= timer_nxt;
      rd_data  <= rd_data_nxt;
      vga_ack  <= vga_ack_nxt;
      cpu_ack  <= cpu_ack_nxt;
      uart_ack <= uart_ack_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_uart_nxt  = rr_uart;
    timer_nxt    = timer;
    rd_data_nxt  = rd_data;
    vga_ack_nxt  = 1'b0;
    cpu_ack_nxt  = 1'b0;
    uart_ack_nxt = 1'b0;
    bus_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (pick != OWN_NONE) begin
          owner_nxt = pick;
          state_nxt = BUSY;
          if (pick == OWN_CPU)  rr_uart_nxt = 1'b1;
          if (pick == OWN_UART) rr_uart_nxt = 1'b0;
        end
      end
      BUSY: begin
        timer_nxt = timer + TW'(1);
        // A late ack in the final cycle still counts as success.
        if (mem_ack || timer == TW'(TIMEOUT - 1)) begin
          state_nxt    = ACK;
          rd_data_nxt  = mem_ack ? mem_rdat : 32'h0;
          bus_err_nxt  = !mem_ack;
          vga_ack_nxt  = (owner == OWN_VGA);
          cpu_ack_nxt  = (owner == OWN_CPU);
          uart_ack_nxt = (owner == OWN_UART);
        end
      end
      ACK: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Memory side is a pure function of state and the latched owner's live inputs.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_adr  = 32'h0;
    mem_wdat = 32'h0;
    mem_sel  = 4'h0;
    grant    = (state == IDLE) ? OWN_NONE : owner;
    if (state == BUSY) begin
      mem_req = 1'b1;
      case (owner)
        OWN_CPU: begin
          mem_we   = cpu_we;
          mem_adr  = cpu_adr;
          mem_wdat = cpu_wdat;
          mem_sel  = cpu_sel;
        end
        OWN_VGA: begin
          mem_adr = vga_adr;
          mem_sel = 4'hf;
        end
        OWN_UART: begin
          mem_we   = 1'b1;
          mem_adr  = uart_adr;
          mem_wdat = uart_wdat;
          mem_sel  = uart_sel;
        end
        default: mem_req = 1'b1;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port main memory between three requesters over a req/ack handshake: VGA (read-only), CPU (read/write) and UART program loader (write-only).
- VGA has fixed highest priority. CPU and UART alternate round-robin.
- The arbiter holds a grant until memory acknowledges the transaction, so nothing is pre-empted mid-transfer.
- It sits between the three requester ports and the memory controller, and replaces per-cycle time-slicing with explicit handshakes.

Parameters:
- TIMEOUT, 16: maximum cycles in BUSY without mem_ack before the transaction is aborted with bus_err.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- vga_prefetch  in  1  VGA active window imminent; blocks new CPU/UART grants
- vga_req  in  1  VGA read request; held until vga_ack
- vga_adr  in  32  VGA read address
- vga_ack  out  1  one-cycle completion pulse to VGA
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  CPU write enable (0 = read)
- cpu_adr  in  32  CPU address
- cpu_wdat  in  32  CPU write data
- cpu_sel  in  4  CPU byte selects
- cpu_ack  out  1  one-cycle completion pulse to CPU
- uart_req  in  1  UART write request; held until uart_ack
- uart_adr  in  32  UART write address
- uart_wdat  in  32  UART write data
- uart_sel  in  4  UART byte selects
- uart_ack  out  1  one-cycle completion pulse to UART
- rd_data  out  32  read data, shared; valid only in the cycle of the owner's ack
- bus_err  out  1  one-cycle pulse with ack when the transaction timed out
- grant  out  2  current owner: 00 CPU, 01 VGA, 10 UART, 11 none
- mem_req  out  1  memory request; high for the whole BUSY state
- mem_we  out  1  memory write enable
- mem_adr  out  32  memory address
- mem_wdat  out  32  memory write data
- mem_sel  out  4  memory byte selects
- mem_rdat  in  32  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset values:
  - state IDLE, grant=11, rr_next=CPU, timer=0.
  - All acks, bus_err, mem_req, mem_we = 0.
  - mem_adr, mem_wdat, mem_sel, rd_data = 0.
- FSM states: IDLE, BUSY, ACK.
- IDLE: on a clock edge with any eligible req, latch the owner and go to BUSY; otherwise stay.
- Owner selection, in order:
  - vga_req wins.
  - Else, if vga_prefetch=1, no grant.
  - Else, if both cpu_req and uart_req are high, grant rr_next.
  - Else, grant whichever of cpu_req/uart_req is high.
- Round-robin pointer: on granting CPU, rr_next<=UART; on granting UART, rr_next<=CPU. VGA grants leave rr_next unchanged.
- BUSY:
  - mem_req=1. mem_* driven combinationally from the latched owner's inputs.
  - VGA: mem_we=0, mem_sel=1111, mem_wdat=0. UART: mem_we=1.
  - timer increments each cycle.
  - mem_ack=1: go to ACK; rd_data<=mem_rdat; owner ack and bus_err=0 registered for ACK.
  - timer==TIMEOUT-1 with mem_ack=0: go to ACK; rd_data<=0; bus_err=1 during ACK.
  - mem_ack and timeout in the same cycle: mem_ack wins, no error.
- ACK:
  - Exactly one of vga_ack/cpu_ack/uart_ack is high, plus bus_err if applicable.
  - mem_req=0. Next state is always IDLE, which gives the requester one cycle to drop req.
  - timer cleared. grant=11 in IDLE only; in BUSY and ACK it shows the owner.
- Latency:
  - req high at edge N (IDLE) → mem_req high after edge N.
  - mem_ack at edge M → ack high after M, for one cycle.
  - Minimum 3 cycles per transaction.
- vga_prefetch blocks only new CPU/UART grants. An in-flight CPU/UART transaction always completes; VGA waits for it.
- A requester dropping req during BUSY is a protocol violation. The transaction still completes and the ack is still issued.
- rst asserted mid-transaction: immediate return to reset values, mem_req drops asynchronously, no ack issued.
- rd_data holds its value until the next ACK.

Test Plan:
- CPU read at 0x0000_0040, memory acks after 2 cycles with 0x1234_5678 → mem_req high 3 cycles, then cpu_ack=1 and rd_data=0x1234_5678 for one cycle, grant returns to 11.
- cpu_req and uart_req high together from reset, each re-requesting immediately → grant sequence CPU, UART, CPU, UART; uart writes show mem_we=1.
- cpu_req, uart_req and vga_req all high → VGA served first with mem_we=0 and mem_sel=1111, then CPU, then UART.
- vga_prefetch=1 with cpu_req high and no vga_req → no grant. Lower vga_prefetch → CPU granted on the next edge.
- Memory never acks a UART write → after 16 BUSY cycles, uart_ack=1 and bus_err=1 with rd_data=0. mem_ack on exactly the 16th cycle instead → bus_err=0.
- rst pulsed during BUSY of a CPU write → mem_req=0 immediately, no cpu_ack, grant=11, rr_next=CPU afterwards.
